// File: rtl/ifid_inst_queue.sv
// ifid_inst_queue: circular instruction buffer between fetch and decode.
// Fetch pushes {pc, inst} pairs. Decode pops the oldest entry using a
// valid/ready handshake. A redirect (flush) discards everything that is queued.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready to in_ready. A full queue does not accept a push in the
// same cycle as a pop.
module ifid_inst_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [63:0]   in_bus,
  output logic          in_ready,
  output logic          out_valid,
  output logic [63:0]   out_bus,
  output logic          out_adel,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_bus   = mem[rd_ptr];
  assign out_adel  = out_valid & (out_bus[33:32] != 2'b00);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Pointer and occupancy update: reset, then flush, then normal push/pop.
  // NOTE: all sequential state uses non-blocking assignments, so every
  // register in this block samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: write the slot at wr_ptr on an accepted push.
  // NOTE: the memory has no reset. Occupancy is tracked by count, so stale
  // contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push) begin
      mem[wr_ptr] <= in_bus;
    end
  end

endmodule

// File: tb/tb_ifid_inst_queue.sv
// Testbench for ifid_inst_queue. A reference model built on a SystemVerilog
// queue is compared against the DUT outputs on every cycle. Directed
// scenarios run first, followed by a randomized phase.
module tb_ifid_inst_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic [63:0]   in_bus;
  logic          in_ready;
  logic          out_valid;
  logic [63:0]   out_bus;
  logic          out_adel;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  int n_vec  = 0;
  int n_fail = 0;

  logic [63:0] model_q [$];

  ifid_inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_bus    (in_bus),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bus   (out_bus),
    .out_adel  (out_adel),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output with the reference queue state.
  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    check("count",     64'(count),     64'(sz));
    check("in_ready",  64'(in_ready),  64'(sz != DEPTH));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    if (sz != 0) begin
      check("out_bus",  out_bus,        model_q[0]);
      check("out_adel", 64'(out_adel),  64'(model_q[0][33:32] != 2'b00));
    end else begin
      check("out_adel", 64'(out_adel),  64'(0));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic apply(input logic iv, input logic [63:0] b, input logic ordy,
                       input logic fl, input logic rn);
    bit do_push, do_pop;
    resetn    = rn;
    in_valid  = iv;
    in_bus    = b;
    out_ready = ordy;
    flush     = fl;
    if (!rn || fl) begin
      model_q.delete();
    end else begin
      do_push = iv && (model_q.size() < DEPTH);
      do_pop  = ordy && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(b);
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [63:0] mk(input logic [31:0] pc);
    logic [31:0] inst;
    inst = $urandom;
    return {pc, inst};
  endfunction

  initial begin
    logic [31:0] pc;
    resetn = 1'b0; in_valid = 1'b0; in_bus = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset state
    apply(0, '0, 0, 0, 0);
    apply(0, '0, 1, 0, 1);

    // 1: three pushes with decode stalled
    apply(1, mk(32'h34), 0, 0, 1);
    apply(1, mk(32'h38), 0, 0, 1);
    apply(1, mk(32'h3C), 0, 0, 1);
    check("t1_head_pc", 64'(out_bus[63:32]), 64'h34);

    // 2: fill to full, a fifth push is ignored, then one pop frees a slot
    apply(1, mk(32'h40), 0, 0, 1);
    check("t2_full", 64'(in_ready), 64'(0));
    apply(1, mk(32'h44), 0, 0, 1);
    apply(1, mk(32'h48), 1, 0, 1);
    apply(0, '0, 0, 0, 1);

    // Drain, then 3: steady stream of 20 cycles
    apply(0, '0, 1, 1, 1);
    pc = 32'h34;
    for (int i = 0; i < 20; i++) begin
      apply(1, mk(pc), 1, 0, 1);
      check("t3_stream_pc", 64'(out_bus[63:32]), 64'(pc));
      pc += 4;
    end

    // 4: reach count = 3, then flush together with a push and a pop
    apply(0, '0, 1, 1, 1);
    for (int i = 0; i < 3; i++) apply(1, mk(32'h100 + 32'(4*i)), 0, 0, 1);
    apply(1, mk(32'h200), 1, 1, 1);
    check("t4_flushed", 64'(count), 64'(0));
    apply(0, '0, 0, 0, 1);

    // 5: a misaligned pc reaches the head, followed by an aligned one
    apply(1, mk(32'h36), 0, 0, 1);
    check("t5_adel", 64'(out_adel), 64'(1));
    apply(1, mk(32'h38), 1, 0, 1);
    check("t5_noadel", 64'(out_adel), 64'(0));

    // 6: reset with count = 2
    apply(1, mk(32'h3C), 0, 0, 1);
    check("t6_pre", 64'(count), 64'(2));
    apply(1, mk(32'h40), 1, 0, 0);
    check("t6_reset", 64'(count), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      apply(1'($urandom_range(1)), mk(rpc), 1'($urandom_range(1)),
            1'($urandom_range(40) == 0), 1'($urandom_range(200) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
